multi_proxy_controller: RTL and testbench
=========================================

Name: multi_proxy_controller

Overview:
- Per-column weight-proxy repair controller that covers up to NUM_PROXIES faulty PEs in one column, not just the first.
- On STW completion it latches the fault mask and assigns faults to proxy slots in ascending row order.
- Each slot gets a two-cycle stationary-weight load; all slots then switch to matmul together.
- Sits between the STW/BIST result path and the column's proxy PEs. Tracks faults it cannot cover, honours stall in every state, and rearms on weight reload.

Parameters:
- ROWS, 4: PEs per column.
- COL_IDX, 0: column served by this instance.
- WORD_SIZE, 16: datapath width in bits, signed.
- NUM_PROXIES, 2: proxy slots per column, range 1..ROWS.
- TIMEOUT_CYCLES, 64: map-done wait limit; used only with PROXY_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- stall  in  1  freezes FSM, counters and slot pipes.
- stw_complete  in  1  one-cycle pulse; stw_result_mat is valid.
- stw_result_mat  in  ROWS  1 = PE passed, 0 = faulty.
- proxy_map_done  in  1  proxy PE mapping ready.
- weight_reload  in  1  new stationary weights incoming; clears all assignments.
- fpe_in_weight  in  WORD_SIZE  weight of the PE selected by fpe_idx_sel.
- rcm_left_in  in  NUM_PROXIES*WORD_SIZE  per-slot recompute left operand.
- proxy_top_in  in  NUM_PROXIES*WORD_SIZE  per-slot proxy top input.
- fpe_idx_sel  out  clog2(ROWS)  row currently being assigned.
- slot_sel  out  clog2(NUM_PROXIES)+1  slot currently being loaded.
- fault_detected  out  1  latched mask is non-zero.
- fault_count  out  clog2(ROWS)+1  popcount of latched fault mask.
- proxy_en  out  ROWS  one-hot-per-fault mask of covered rows.
- unrepaired_mask  out  ROWS  faulty rows left without a slot.
- load_proxy  out  1  a stationary load is in progress.
- proxy_matmul  out  1  proxies are computing.
- proxy_settings  out  3  {stat_bit_in, fsm_out_select_in, fsm_op2_select_in}.
- fpe_weight  out  WORD_SIZE  weight being driven to the proxy.
- proxy_left_in  out  NUM_PROXIES*WORD_SIZE  registered per-slot left operand.
- proxy_out_valid  out  NUM_PROXIES  per-slot result valid.
- proxy_stalled_top_in  out  NUM_PROXIES*WORD_SIZE  one-cycle delayed proxy_top_in.
- busy  out  1  FSM is not in IDLE.

Behaviour:
- Reset (rst low, async):
  - Every output and register is 0.
  - FSM goes to IDLE; slot pointer is 0.
- IDLE:
  - On stw_complete, latch fault_mask = ~stw_result_mat and set fault_count = popcount.
  - Mask non-zero: go to ASSIGN. Mask zero: stay in IDLE with fault_detected=0.
- ASSIGN:
  - proxy_settings=000, load_proxy=0.
  - Wait for proxy_map_done.
  - Then fpe_idx_sel = lowest set bit of the remaining mask, slot_sel = slot pointer, go to LOAD1.
- LOAD1:
  - Drive fpe_weight <= fpe_in_weight, proxy_settings=001, load_proxy=1.
  - Go to LOAD2.
- LOAD2:
  - Re-capture fpe_weight, settings stay 001.
  - Set proxy_en[idx], clear idx from the remaining mask, increment slot pointer.
  - If the remaining mask is non-zero and slots remain, go to ASSIGN; otherwise go to COMPUTE.
- COMPUTE:
  - fpe_weight=0, load_proxy=0, proxy_matmul=1, proxy_settings=110.
  - unrepaired_mask = remaining mask (sticky until reload).
  - Hold until weight_reload.
- Stall: when stall=1, state, pointers and all registered outputs hold their values, in every state.
- weight_reload:
  - From any state, next cycle goes to IDLE.
  - Clears proxy_en, unrepaired_mask, fault_count, slot pointer, and the slot pipes.
  - Has priority over stall and over stw_complete in the same cycle; that stw_complete is dropped.
- stw_complete outside IDLE is ignored.
- Slot pipe, per slot s, when not stalled:
  - proxy_left_in[s] <= (slot s assigned) ? rcm_left_in[s] : 0.
  - proxy_out_valid[s] <= (previous proxy_left_in[s] != 0) && state==COMPUTE && proxy_map_done.
  - proxy_stalled_top_in[s] <= proxy_top_in[s].
- Widths: all width arithmetic is unsigned. Slot pointer saturates at NUM_PROXIES.
- Output port signals are driven by registers; fault_detected is derived from the latched fault_mask.

Optional Feature:
- Macro: PROXY_TIMEOUT_EN.
- Defined:
  - A counter runs in ASSIGN while proxy_map_done=0; it holds on stall and clears on leaving ASSIGN.
  - When it reaches TIMEOUT_CYCLES, map_timeout (extra 1-bit output) is set sticky.
  - The remaining mask is copied into unrepaired_mask and the FSM goes to COMPUTE with the slots loaded so far.
  - map_timeout clears on weight_reload or reset.
- Undefined: ASSIGN waits indefinitely; there is no map_timeout port and no counter.

Decomposition:
- Package proxy_pkg:
  - State enum {IDLE, ASSIGN, LOAD1, LOAD2, COMPUTE}.
  - Setting constants PS_IDLE=3'b000, PS_LOAD=3'b001, PS_MATMUL=3'b110.
  - Width helper functions.
- Sub-module proxy_slot_pipe, one instance per slot: registers left_in, out_valid and stalled top_in, with stall and clear inputs.

Test Plan:
- ROWS=4, NUM_PROXIES=2, stw_result_mat=4'b1111 -> stays IDLE, fault_detected=0, busy returns to 0.
- stw_result_mat=4'b1010, map_done=1 -> fpe_idx_sel 0 then 2, proxy_en=0101, fault_count=2, COMPUTE with settings=110, unrepaired_mask=0.
- stw_result_mat=4'b0000 -> rows 0 and 1 are proxied, unrepaired_mask=1100, fault_count=4.
- Stall held 3 cycles during LOAD1 -> state, fpe_weight and settings=001 frozen; LOAD2 follows 1 cycle after stall drops.
- COMPUTE, rcm_left_in slot0=16'sd5 -> proxy_left_in[0]=5 after 1 cycle, proxy_out_valid[0]=1 after 2; a 0 input yields valid=0.
- weight_reload together with stw_complete mid-LOAD2 -> IDLE, proxy_en=0, no new latch. Async rst low mid-COMPUTE -> all outputs 0 immediately.

Source files
------------

// File: rtl/proxy_pkg.sv
// Shared types and constants for the multi-slot weight-proxy repair controller.
// FSM states, proxy setting encodings and the width helpers live here.
package proxy_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ASSIGN  = 3'd1,
    LOAD1   = 3'd2,
    LOAD2   = 3'd3,
    COMPUTE = 3'd4
  } state_t;

  // Encoded as {stat_bit_in, fsm_out_select_in, fsm_op2_select_in}
  localparam logic [2:0] PS_IDLE   = 3'b000;
  localparam logic [2:0] PS_LOAD   = 3'b001;
  localparam logic [2:0] PS_MATMUL = 3'b110;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/multi_proxy_controller_if.sv
// Bus between the STW/BIST result path, the column proxy PEs and the controller.
// map_timeout exists only when PROXY_TIMEOUT_EN is defined.
interface multi_proxy_controller_if
  import proxy_pkg::*;
#(
  parameter int ROWS        = 4,
  parameter int WORD_SIZE   = 16,
  parameter int NUM_PROXIES = 2
);
  localparam int IDX_W = idx_width(ROWS);
  localparam int CNT_W = cnt_width(ROWS);
  localparam int PTR_W = cnt_width(NUM_PROXIES);

  logic                             stall;
  logic                             stw_complete;
  logic [ROWS-1:0]                  stw_result_mat;
  logic                             proxy_map_done;
  logic                             weight_reload;
  logic [WORD_SIZE-1:0]             fpe_in_weight;
  logic [NUM_PROXIES*WORD_SIZE-1:0] rcm_left_in;
  logic [NUM_PROXIES*WORD_SIZE-1:0] proxy_top_in;

  logic [IDX_W-1:0]                 fpe_idx_sel;
  logic [PTR_W-1:0]                 slot_sel;
  logic                             fault_detected;
  logic [CNT_W-1:0]                 fault_count;
  logic [ROWS-1:0]                  proxy_en;
  logic [ROWS-1:0]                  unrepaired_mask;
  logic                             load_proxy;
  logic                             proxy_matmul;
  logic [2:0]                       proxy_settings;
  logic [WORD_SIZE-1:0]             fpe_weight;
  logic [NUM_PROXIES*WORD_SIZE-1:0] proxy_left_in;
  logic [NUM_PROXIES-1:0]           proxy_out_valid;
  logic [NUM_PROXIES*WORD_SIZE-1:0] proxy_stalled_top_in;
  logic                             busy;
`ifdef PROXY_TIMEOUT_EN
  logic                             map_timeout;
`endif

  modport slave (
    input  stall, stw_complete, stw_result_mat, proxy_map_done, weight_reload,
           fpe_in_weight, rcm_left_in, proxy_top_in,
    output fpe_idx_sel, slot_sel, fault_detected, fault_count, proxy_en,
           unrepaired_mask, load_proxy, proxy_matmul, proxy_settings, fpe_weight,
           proxy_left_in, proxy_out_valid, proxy_stalled_top_in, busy
`ifdef PROXY_TIMEOUT_EN
    , output map_timeout
`endif
  );

  modport master (
    output stall, stw_complete, stw_result_mat, proxy_map_done, weight_reload,
           fpe_in_weight, rcm_left_in, proxy_top_in,
    input  fpe_idx_sel, slot_sel, fault_detected, fault_count, proxy_en,
           unrepaired_mask, load_proxy, proxy_matmul, proxy_settings, fpe_weight,
           proxy_left_in, proxy_out_valid, proxy_stalled_top_in, busy
`ifdef PROXY_TIMEOUT_EN
    , input map_timeout
`endif
  );

endinterface

// File: rtl/proxy_slot_pipe.sv
// Per-slot operand pipe: gated left operand, result-valid flag and delayed top input.
// clear wins over stall so a weight reload always empties the pipe.
module proxy_slot_pipe #(
  parameter int WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 clear,
  input  logic                 assigned,
  input  logic                 valid_en,
  input  logic [WORD_SIZE-1:0] left_in,
  input  logic [WORD_SIZE-1:0] top_in,
  output logic [WORD_SIZE-1:0] left_out,
  output logic                 valid_out,
  output logic [WORD_SIZE-1:0] top_out
);

  logic [WORD_SIZE-1:0] left_q, left_d;
  logic [WORD_SIZE-1:0] top_q, top_d;
  logic                 valid_q, valid_d;

  always_comb begin
    left_d  = left_q;
    valid_d = valid_q;
    top_d   = top_q;
    if (clear) begin
      left_d  = '0;
      valid_d = 1'b0;
      top_d   = '0;
    end else if (!stall) begin
      left_d  = assigned ? left_in : '0;
      valid_d = (left_q != '0) && valid_en;
      top_d   = top_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      left_q  <= '0;
      valid_q <= 1'b0;
      top_q   <= '0;
    end else begin
      left_q  <= left_d;
      valid_q <= valid_d;
      top_q   <= top_d;
    end
  end

  assign left_out  = left_q;
  assign valid_out = valid_q;
  assign top_out   = top_q;

endmodule

// File: rtl/multi_proxy_controller.sv
// Column repair controller: assigns faulty rows to proxy slots lowest row first.
// Optional PROXY_TIMEOUT_EN bounds the wait for proxy_map_done in ASSIGN.
module multi_proxy_controller
  import proxy_pkg::*;
#(
  parameter int ROWS           = 4,
  parameter int COL_IDX        = 0,
  parameter int WORD_SIZE      = 16,
  parameter int NUM_PROXIES    = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic                      clk,
  input logic                      rst,
  multi_proxy_controller_if.slave  bus
);

  localparam int IDX_W = idx_width(ROWS);
  localparam int CNT_W = cnt_width(ROWS);
  localparam int PTR_W = cnt_width(NUM_PROXIES);

  state_t                 state_q, state_d;
  logic [ROWS-1:0]        mask_q, mask_d;
  logic [ROWS-1:0]        remain_q, remain_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [PTR_W-1:0]       sel_q, sel_d;
  logic [ROWS-1:0]        en_q, en_d;
  logic [ROWS-1:0]        unrep_q, unrep_d;
  logic [NUM_PROXIES-1:0] assigned_q, assigned_d;
  logic [WORD_SIZE-1:0]   weight_q, weight_d;
  logic [2:0]             settings_q, settings_d;
  logic                   load_q, load_d;
  logic                   matmul_q, matmul_d;

  logic [ROWS-1:0]        fail_mask;
  logic [CNT_W-1:0]       pop_cnt;
  logic [IDX_W-1:0]       low_idx;
  logic                   valid_en;

`ifdef PROXY_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic                   timeout_q, timeout_d;
`endif

  assign fail_mask = ~bus.stw_result_mat;

  always_comb begin
    pop_cnt = '0;
    for (int r = 0; r < ROWS; r++) pop_cnt = pop_cnt + CNT_W'(fail_mask[r]);
  end

  // Scan from the top down so the lowest remaining fault wins.
  always_comb begin
    low_idx = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (remain_q[r]) low_idx = IDX_W'(r);
    end
  end

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    remain_d   = remain_q;
    count_d    = count_q;
    ptr_d      = ptr_q;
    idx_d      = idx_q;
    sel_d      = sel_q;
    en_d       = en_q;
    unrep_d    = unrep_q;
    assigned_d = assigned_q;
    weight_d   = weight_q;
`ifdef PROXY_TIMEOUT_EN
    tmo_d      = tmo_q;
    timeout_d  = timeout_q;
`endif
    if (bus.weight_reload) begin
      state_d    = IDLE;
      mask_d     = '0;
      remain_d   = '0;
      count_d    = '0;
      ptr_d      = '0;
      idx_d      = '0;
      sel_d      = '0;
      en_d       = '0;
      unrep_d    = '0;
      assigned_d = '0;
      weight_d   = '0;
`ifdef PROXY_TIMEOUT_EN
      tmo_d      = '0;
      timeout_d  = 1'b0;
`endif
    end else if (!bus.stall) begin
`ifdef PROXY_TIMEOUT_EN
      tmo_d = '0;
`endif
      case (state_q)
        IDLE: begin
          if (bus.stw_complete) begin
            mask_d   = fail_mask;
            remain_d = fail_mask;
            count_d  = pop_cnt;
            if (fail_mask != '0) state_d = ASSIGN;
          end
        end
        ASSIGN: begin
          if (bus.proxy_map_done) begin
            idx_d   = low_idx;
            sel_d   = ptr_q;
            state_d = LOAD1;
          end
`ifdef PROXY_TIMEOUT_EN
          else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_d = 1'b1;
            unrep_d   = remain_q;
            state_d   = COMPUTE;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
`endif
        end
        LOAD1: begin
          weight_d = bus.fpe_in_weight;
          state_d  = LOAD2;
        end
        LOAD2: begin
          weight_d = bus.fpe_in_weight;
          for (int r = 0; r < ROWS; r++) begin
            if (idx_q == IDX_W'(r)) begin
              en_d[r]     = 1'b1;
              remain_d[r] = 1'b0;
            end
          end
          for (int s = 0; s < NUM_PROXIES; s++) begin
            if (ptr_q == PTR_W'(s)) assigned_d[s] = 1'b1;
          end
          ptr_d = (ptr_q >= PTR_W'(NUM_PROXIES)) ? ptr_q : ptr_q + PTR_W'(1);
          if ((remain_d != '0) && (ptr_d < PTR_W'(NUM_PROXIES))) begin
            state_d = ASSIGN;
          end else begin
            unrep_d = remain_d;
            state_d = COMPUTE;
          end
        end
        COMPUTE: weight_d = '0;
        default: state_d = IDLE;
      endcase
    end
  end

  // Settings and strobes are registered against the state being entered.
  always_comb begin
    settings_d = PS_IDLE;
    load_d     = 1'b0;
    matmul_d   = 1'b0;
    case (state_d)
      LOAD1, LOAD2: begin
        settings_d = PS_LOAD;
        load_d     = 1'b1;
      end
      COMPUTE: begin
        settings_d = PS_MATMUL;
        matmul_d   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      mask_q     <= '0;
      remain_q   <= '0;
      count_q    <= '0;
      ptr_q      <= '0;
      idx_q      <= '0;
      sel_q      <= '0;
      en_q       <= '0;
      unrep_q    <= '0;
      assigned_q <= '0;
      weight_q   <= '0;
      settings_q <= PS_IDLE;
      load_q     <= 1'b0;
      matmul_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      remain_q   <= remain_d;
      count_q    <= count_d;
      ptr_q      <= ptr_d;
      idx_q      <= idx_d;
      sel_q      <= sel_d;
      en_q       <= en_d;
      unrep_q    <= unrep_d;
      assigned_q <= assigned_d;
      weight_q   <= weight_d;
      settings_q <= settings_d;
      load_q     <= load_d;
      matmul_q   <= matmul_d;
    end
  end

`ifdef PROXY_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_q     <= tmo_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.map_timeout = timeout_q;
`endif

  assign valid_en = (state_q == COMPUTE) && bus.proxy_map_done;

  logic [NUM_PROXIES*WORD_SIZE-1:0] left_w;
  logic [NUM_PROXIES*WORD_SIZE-1:0] top_w;
  logic [NUM_PROXIES-1:0]           valid_w;

  for (genvar gi = 0; gi < NUM_PROXIES; gi++) begin : g_slot
    proxy_slot_pipe #(
      .WORD_SIZE(WORD_SIZE)
    ) u_pipe (
      .clk       (clk),
      .rst       (rst),
      .stall     (bus.stall),
      .clear     (bus.weight_reload),
      .assigned  (assigned_q[gi]),
      .valid_en  (valid_en),
      .left_in   (bus.rcm_left_in[gi*WORD_SIZE +: WORD_SIZE]),
      .top_in    (bus.proxy_top_in[gi*WORD_SIZE +: WORD_SIZE]),
      .left_out  (left_w[gi*WORD_SIZE +: WORD_SIZE]),
      .valid_out (valid_w[gi]),
      .top_out   (top_w[gi*WORD_SIZE +: WORD_SIZE])
    );
  end

  assign bus.fpe_idx_sel          = idx_q;
  assign bus.slot_sel             = sel_q;
  assign bus.fault_detected       = |mask_q;
  assign bus.fault_count          = count_q;
  assign bus.proxy_en             = en_q;
  assign bus.unrepaired_mask      = unrep_q;
  assign bus.load_proxy           = load_q;
  assign bus.proxy_matmul         = matmul_q;
  assign bus.proxy_settings       = settings_q;
  assign bus.fpe_weight           = weight_q;
  assign bus.proxy_left_in        = left_w;
  assign bus.proxy_out_valid      = valid_w;
  assign bus.proxy_stalled_top_in = top_w;
  assign bus.busy                 = (state_q != IDLE);

endmodule

// File: tb/tb_multi_proxy_controller.sv
// Directed bench for multi_proxy_controller: fault-mask table plus stall, pipe,
// reload-priority and asynchronous reset sequences.
module tb_multi_proxy_controller;

  localparam int ROWS = 4;
  localparam int WS   = 16;
  localparam int NP   = 2;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  multi_proxy_controller_if #(.ROWS(ROWS), .WORD_SIZE(WS), .NUM_PROXIES(NP)) bus_if ();

  multi_proxy_controller #(
    .ROWS(ROWS), .COL_IDX(0), .WORD_SIZE(WS), .NUM_PROXIES(NP), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0] res;
    logic [3:0] en;
    logic [3:0] unrep;
    logic [2:0] cnt;
    int         nloads;
    logic [1:0] idx0;
    logic [1:0] idx1;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reload_pulse();
    bus_if.weight_reload = 1'b1;
    step();
    bus_if.weight_reload = 1'b0;
  endtask

  task automatic start_stw(input logic [3:0] res);
    bus_if.stw_result_mat = res;
    bus_if.stw_complete   = 1'b1;
    step();
    bus_if.stw_complete   = 1'b0;
  endtask

  initial begin
    logic [1:0] idx_seen [2];
    int         nloads;
    logic       done;
    logic       prev_load;

    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    bus_if.stall          = 1'b0;
    bus_if.stw_complete   = 1'b0;
    bus_if.stw_result_mat = '1;
    bus_if.proxy_map_done = 1'b0;
    bus_if.weight_reload  = 1'b0;
    bus_if.fpe_in_weight  = '0;
    bus_if.rcm_left_in    = '0;
    bus_if.proxy_top_in   = '0;

    vecs[0] = '{res: 4'b1111, en: 4'b0000, unrep: 4'b0000, cnt: 3'd0, nloads: 0, idx0: 2'd0, idx1: 2'd0};
    vecs[1] = '{res: 4'b1010, en: 4'b0101, unrep: 4'b0000, cnt: 3'd2, nloads: 2, idx0: 2'd0, idx1: 2'd2};
    vecs[2] = '{res: 4'b0000, en: 4'b0011, unrep: 4'b1100, cnt: 3'd4, nloads: 2, idx0: 2'd0, idx1: 2'd1};
    vecs[3] = '{res: 4'b0111, en: 4'b1000, unrep: 4'b0000, cnt: 3'd1, nloads: 1, idx0: 2'd3, idx1: 2'd0};
    vecs[4] = '{res: 4'b0110, en: 4'b1001, unrep: 4'b0000, cnt: 3'd2, nloads: 2, idx0: 2'd0, idx1: 2'd3};
    vecs[5] = '{res: 4'b0001, en: 4'b0110, unrep: 4'b1000, cnt: 3'd3, nloads: 2, idx0: 2'd1, idx1: 2'd2};

    #2;
    check("reset_busy", 64'(bus_if.busy), 64'd0);
    check("reset_en", 64'(bus_if.proxy_en), 64'd0);
    check("reset_settings", 64'(bus_if.proxy_settings), 64'd0);
    check("reset_count", 64'(bus_if.fault_count), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    bus_if.proxy_map_done = 1'b1;

    for (int i = 0; i < 6; i++) begin
      reload_pulse();
      bus_if.fpe_in_weight = 16'hA5A0 + 16'(i);
      start_stw(vecs[i].res);
      check($sformatf("v%0d_detected", i), 64'(bus_if.fault_detected), 64'(vecs[i].cnt != 0));
      check($sformatf("v%0d_count", i), 64'(bus_if.fault_count), 64'(vecs[i].cnt));
      if (vecs[i].nloads == 0) begin
        step();
        check($sformatf("v%0d_idle_busy", i), 64'(bus_if.busy), 64'd0);
        check($sformatf("v%0d_idle_en", i), 64'(bus_if.proxy_en), 64'd0);
        $display("vec %0d res=%b no faults busy=%0d", i, vecs[i].res, bus_if.busy);
      end else begin
        nloads    = 0;
        done      = 1'b0;
        prev_load = bus_if.load_proxy;
        for (int c = 0; c < 20 && !done; c++) begin
          step();
          if (bus_if.load_proxy && !prev_load) begin
            if (nloads < 2) idx_seen[nloads] = bus_if.fpe_idx_sel;
            nloads++;
          end
          prev_load = bus_if.load_proxy;
          if (bus_if.proxy_matmul) done = 1'b1;
        end
        check($sformatf("v%0d_reached_compute", i), 64'(done), 64'd1);
        check($sformatf("v%0d_nloads", i), 64'(nloads), 64'(vecs[i].nloads));
        check($sformatf("v%0d_idx0", i), 64'(idx_seen[0]), 64'(vecs[i].idx0));
        if (vecs[i].nloads > 1)
          check($sformatf("v%0d_idx1", i), 64'(idx_seen[1]), 64'(vecs[i].idx1));
        check($sformatf("v%0d_en", i), 64'(bus_if.proxy_en), 64'(vecs[i].en));
        check($sformatf("v%0d_unrep", i), 64'(bus_if.unrepaired_mask), 64'(vecs[i].unrep));
        check($sformatf("v%0d_settings", i), 64'(bus_if.proxy_settings), 64'(3'b110));
        check($sformatf("v%0d_busy", i), 64'(bus_if.busy), 64'd1);
        $display("vec %0d res=%b en=%b unrep=%b count=%0d", i, vecs[i].res,
                 bus_if.proxy_en, bus_if.unrepaired_mask, bus_if.fault_count);
      end
    end

    // weight_reload with stw_complete (and stall) while in LOAD2
    reload_pulse();
    start_stw(4'b1010);
    step();
    step();
    bus_if.weight_reload  = 1'b1;
    bus_if.stw_complete   = 1'b1;
    bus_if.stw_result_mat = 4'b0000;
    bus_if.stall          = 1'b1;
    step();
    bus_if.weight_reload  = 1'b0;
    bus_if.stw_complete   = 1'b0;
    bus_if.stall          = 1'b0;
    check("rl_busy", 64'(bus_if.busy), 64'd0);
    check("rl_en", 64'(bus_if.proxy_en), 64'd0);
    check("rl_count", 64'(bus_if.fault_count), 64'd0);
    check("rl_load", 64'(bus_if.load_proxy), 64'd0);
    step();
    check("rl_no_latch_busy", 64'(bus_if.busy), 64'd0);
    check("rl_no_latch_count", 64'(bus_if.fault_count), 64'd0);
    $display("reload during LOAD2: busy=%0d en=%b", bus_if.busy, bus_if.proxy_en);

    // Stall held for three cycles in LOAD1
    reload_pulse();
    bus_if.fpe_in_weight = 16'h1234;
    start_stw(4'b1110);
    step();
    check("st_load1_load", 64'(bus_if.load_proxy), 64'd1);
    bus_if.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("st_hold%0d_settings", k), 64'(bus_if.proxy_settings), 64'(3'b001));
      check($sformatf("st_hold%0d_weight", k), 64'(bus_if.fpe_weight), 64'd0);
      check($sformatf("st_hold%0d_matmul", k), 64'(bus_if.proxy_matmul), 64'd0);
    end
    bus_if.stall = 1'b0;
    step();
    check("st_load2_weight", 64'(bus_if.fpe_weight), 64'h1234);
    check("st_load2_load", 64'(bus_if.load_proxy), 64'd1);
    check("st_load2_matmul", 64'(bus_if.proxy_matmul), 64'd0);
    step();
    check("st_compute_matmul", 64'(bus_if.proxy_matmul), 64'd1);
    check("st_compute_en", 64'(bus_if.proxy_en), 64'(4'b0001));
    $display("stall in LOAD1: en=%b settings=%b", bus_if.proxy_en, bus_if.proxy_settings);

    // Slot pipes in COMPUTE: slot 0 assigned, slot 1 not
    bus_if.rcm_left_in  = {16'sd7, 16'sd5};
    bus_if.proxy_top_in = {16'h2222, 16'h1111};
    step();
    check("pipe_left", 64'(bus_if.proxy_left_in), 64'h0000_0005);
    check("pipe_top", 64'(bus_if.proxy_stalled_top_in), 64'h2222_1111);
    check("pipe_valid0", 64'(bus_if.proxy_out_valid), 64'(2'b00));
    step();
    check("pipe_valid1", 64'(bus_if.proxy_out_valid), 64'(2'b01));
    bus_if.rcm_left_in = {16'sd7, 16'sd0};
    step();
    check("pipe_zero_left", 64'(bus_if.proxy_left_in), 64'd0);
    check("pipe_zero_valid_lag", 64'(bus_if.proxy_out_valid), 64'(2'b01));
    step();
    check("pipe_zero_valid", 64'(bus_if.proxy_out_valid), 64'(2'b00));
    bus_if.rcm_left_in = {16'sd7, 16'sd5};
    step();
    $display("slot pipe: left=%h valid=%b", bus_if.proxy_left_in, bus_if.proxy_out_valid);

    // Asynchronous reset between clock edges while in COMPUTE
    #3;
    rst = 1'b0;
    #1;
    check("arst_matmul", 64'(bus_if.proxy_matmul), 64'd0);
    check("arst_en", 64'(bus_if.proxy_en), 64'd0);
    check("arst_settings", 64'(bus_if.proxy_settings), 64'd0);
    check("arst_busy", 64'(bus_if.busy), 64'd0);
    check("arst_detected", 64'(bus_if.fault_detected), 64'd0);
    check("arst_left", 64'(bus_if.proxy_left_in), 64'd0);
    check("arst_count", 64'(bus_if.fault_count), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    step();
    check("post_rst_busy", 64'(bus_if.busy), 64'd0);
    $display("async reset: busy=%0d en=%b", bus_if.busy, bus_if.proxy_en);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
